// File: rtl/vm_change_dispenser.sv
// Vending-machine change dispenser: pays a dollars/cents refund as greedy coins (dollar/quarter/dime/nickel).
// Latency: first coin offered one cycle after an accepted start; done/error pulse one cycle after the last coin or the rejection.
// Backpressure: the offered coin, remaining and coins_issued hold while eject_ready is low; eject_valid stays high until the coin is accepted.
module vm_change_dispenser (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  dollars,
  input  logic [7:0]  cents,
  input  logic        eject_ready,
  output logic        eject_valid,
  output logic [1:0]  eject_coin,
  output logic [14:0] remaining,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  coins_issued
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPENSE = 2'd1,
    DONE     = 2'd2,
    ERR      = 2'd3
  } state_t;

  localparam logic [1:0] COIN_DOLLAR  = 2'b00;
  localparam logic [1:0] COIN_QUARTER = 2'b01;
  localparam logic [1:0] COIN_DIME    = 2'b10;
  localparam logic [1:0] COIN_NICKEL  = 2'b11;

  state_t      state;
  state_t      state_nxt;
  logic [14:0] rem_q;
  logic [14:0] rem_nxt;
  logic [7:0]  cnt_q;
  logic [7:0]  cnt_nxt;

  logic [14:0] total;
  logic        amt_ok;
  logic [1:0]  coin_sel;
  logic [14:0] coin_val;

  // Refund total in cents; 255*100+99 fits in 15 bits, so no overflow is possible.
  assign total  = ({7'd0, dollars} * 15'd100) + {7'd0, cents};
  assign amt_ok = (cents <= 8'd99) && ((cents % 8'd5) == 8'd0);

  // Greedy coin choice from the registered remaining amount.
  always_comb begin
    coin_sel = COIN_NICKEL;
    coin_val = 15'd5;
    if (rem_q >= 15'd100) begin
      coin_sel = COIN_DOLLAR;
      coin_val = 15'd100;
    end else if (rem_q >= 15'd25) begin
      coin_sel = COIN_QUARTER;
      coin_val = 15'd25;
    end else if (rem_q >= 15'd10) begin
      coin_sel = COIN_DIME;
      coin_val = 15'd10;
    end
  end

  // State, remaining amount and coin counter registers; rst wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rem_q <= 15'd0;
      cnt_q <= 8'd0;
    end else begin
      state <= state_nxt;
      rem_q <= rem_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  // Next-state logic and outputs decoded from the registered state.
  always_comb begin
    state_nxt   = state;
    rem_nxt     = rem_q;
    cnt_nxt     = cnt_q;
    eject_valid = 1'b0;
    eject_coin  = 2'b00;
    busy        = 1'b1;
    done        = 1'b0;
    error       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          cnt_nxt = 8'd0;
          if (!amt_ok) begin
            rem_nxt   = 15'd0;
            state_nxt = ERR;
          end else begin
            rem_nxt   = total;
            state_nxt = (total == 15'd0) ? DONE : DISPENSE;
          end
        end
      end
      DISPENSE: begin
        eject_valid = 1'b1;
        eject_coin  = coin_sel;
        if (eject_ready) begin
          // remaining is always a nonzero multiple of 5 here, so the subtraction cannot underflow.
          rem_nxt = rem_q - coin_val;
          if (cnt_q != 8'd255) begin
            cnt_nxt = cnt_q + 8'd1;
          end
          if (rem_nxt == 15'd0) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      ERR: begin
        error     = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign remaining    = rem_q;
  assign coins_issued = cnt_q;

endmodule

// File: tb/tb_vm_change_dispenser.sv
// Self-checking bench for vm_change_dispenser: coin-list reference model plus directed literal checks.
// Inputs change and outputs are checked on the falling edge; the model advances on the rising edge.
// The saturation case uses random eject_ready with a bounded cycle budget.
module tb_vm_change_dispenser;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  dollars;
  logic [7:0]  cents;
  logic        eject_ready;
  logic        eject_valid;
  logic [1:0]  eject_coin;
  logic [14:0] remaining;
  logic        busy;
  logic        done;
  logic        error;
  logic [7:0]  coins_issued;

  int n_chk  = 0;
  int n_fail = 0;
  bit cmp_en = 0;

  // Reference model: pending coins as a list, plus owed amount and count.
  int m_q[$];
  int m_rem  = 0;
  int m_cnt  = 0;
  bit m_done = 0;
  bit m_err  = 0;

  vm_change_dispenser dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .dollars      (dollars),
    .cents        (cents),
    .eject_ready  (eject_ready),
    .eject_valid  (eject_valid),
    .eject_coin   (eject_coin),
    .remaining    (remaining),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .coins_issued (coins_issued)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int coin_value(input int c);
    case (c)
      0: return 100;
      1: return 25;
      2: return 10;
      default: return 5;
    endcase
  endfunction

  task automatic model_step();
    int r;
    if (rst) begin
      m_q.delete();
      m_rem  = 0;
      m_cnt  = 0;
      m_done = 0;
      m_err  = 0;
    end else if (m_done || m_err) begin
      m_done = 0;
      m_err  = 0;
    end else if (m_q.size() > 0) begin
      if (eject_ready) begin
        m_rem = m_rem - coin_value(m_q[0]);
        void'(m_q.pop_front());
        if (m_cnt < 255) m_cnt++;
        if (m_q.size() == 0) m_done = 1;
      end
    end else if (start) begin
      m_cnt = 0;
      if (int'(cents) > 99 || (int'(cents) % 5) != 0) begin
        m_err = 1;
        m_rem = 0;
      end else begin
        m_rem = int'(dollars) * 100 + int'(cents);
        r = m_rem;
        while (r >= 100) begin m_q.push_back(0); r -= 100; end
        while (r >= 25)  begin m_q.push_back(1); r -= 25;  end
        while (r >= 10)  begin m_q.push_back(2); r -= 10;  end
        while (r >= 5)   begin m_q.push_back(3); r -= 5;   end
        if (m_rem == 0) m_done = 1;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Cycle-by-cycle comparison of every output against the model.
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("m_valid", eject_valid, (m_q.size() > 0));
      chk("m_coin", eject_coin, (m_q.size() > 0) ? m_q[0] : 0);
      chk("m_remaining", remaining, m_rem);
      chk("m_coins_issued", coins_issued, m_cnt);
      chk("m_busy", busy, (m_q.size() > 0) || m_done || m_err);
      chk("m_done", done, m_done);
      chk("m_error", error, m_err);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_out(input string nm, input int v, input int c, input int rem, input int cnt,
                         input int b, input int d, input int e);
    chk({nm, "_valid"}, eject_valid, v);
    chk({nm, "_coin"}, eject_coin, c);
    chk({nm, "_remaining"}, remaining, rem);
    chk({nm, "_coins_issued"}, coins_issued, cnt);
    chk({nm, "_busy"}, busy, b);
    chk({nm, "_done"}, done, d);
    chk({nm, "_error"}, error, e);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dollars = 8'd0; cents = 8'd0; eject_ready = 1'b0;
    tick();
    cmp_en = 1;
    tick();
    chk_out("reset", 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick();

    // $1.40 with ready held high: dollar, quarter, dime, nickel back to back.
    dollars = 8'd1; cents = 8'd40; start = 1'b1; eject_ready = 1'b1;
    tick();
    start = 1'b0; dollars = 8'd7; cents = 8'd3;
    chk_out("p140_c0", 1, 0, 140, 0, 1, 0, 0);
    tick(); chk_out("p140_c1", 1, 1, 40, 1, 1, 0, 0);
    tick(); chk_out("p140_c2", 1, 2, 15, 2, 1, 0, 0);
    tick(); chk_out("p140_c3", 1, 3, 5, 3, 1, 0, 0);
    tick(); chk_out("p140_done", 0, 0, 0, 4, 1, 1, 0);
    tick(); chk_out("p140_idle", 0, 0, 0, 4, 0, 0, 0);

    // Zero refund goes straight to done.
    dollars = 8'd0; cents = 8'd0; start = 1'b1;
    tick(); start = 1'b0;
    chk_out("zero_done", 0, 0, 0, 0, 1, 1, 0);
    tick(); chk_out("zero_idle", 0, 0, 0, 0, 0, 0, 0);

    // Invalid cents: not a multiple of 5, then out of range.
    cents = 8'd37; start = 1'b1;
    tick(); start = 1'b0;
    chk_out("c37_err", 0, 0, 0, 0, 1, 0, 1);
    tick(); chk_out("c37_idle", 0, 0, 0, 0, 0, 0, 0);
    cents = 8'd100; start = 1'b1;
    tick(); start = 1'b0;
    chk_out("c100_err", 0, 0, 0, 0, 1, 0, 1);
    tick(); chk_out("c100_idle", 0, 0, 0, 0, 0, 0, 0);

    // 30c with the mechanism stalled for 5 cycles.
    cents = 8'd30; eject_ready = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_out("stall_hold", 1, 1, 30, 0, 1, 0, 0);
      if (i == 4) eject_ready = 1'b1;
      tick();
    end
    chk_out("stall_c1", 1, 3, 5, 1, 1, 0, 0);
    tick(); chk_out("stall_done", 0, 0, 0, 2, 1, 1, 0);
    tick();

    // $3.00 abandoned by reset after the first coin.
    dollars = 8'd3; cents = 8'd0; start = 1'b1;
    tick(); start = 1'b0;
    chk_out("rst_c0", 1, 0, 300, 0, 1, 0, 0);
    tick(); chk_out("rst_c1", 1, 0, 200, 1, 1, 0, 0);
    rst = 1'b1;
    tick(); chk_out("rst_abort", 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick(); chk_out("rst_nodone", 0, 0, 0, 0, 0, 0, 0);

    // 50c payout with start re-asserted mid-payout.
    dollars = 8'd0; cents = 8'd50; start = 1'b1;
    tick();
    dollars = 8'd9; cents = 8'd0;
    chk_out("restart_c0", 1, 1, 50, 0, 1, 0, 0);
    tick(); chk_out("restart_c1", 1, 1, 25, 1, 1, 0, 0);
    tick(); chk_out("restart_done", 0, 0, 0, 2, 1, 1, 0);
    start = 1'b0;
    tick(); chk_out("restart_idle", 0, 0, 0, 2, 0, 0, 0);

    // Largest valid refund, 260 coins with a random-ready mechanism: counter saturates.
    dollars = 8'd255; cents = 8'd95; start = 1'b1; eject_ready = 1'b1;
    tick(); start = 1'b0;
    chk("max_total", remaining, 25595);
    for (int i = 0; i < 4000 && !done; i++) begin
      eject_ready = 1'($urandom_range(0, 1));
      tick();
    end
    chk("max_done_seen", done, 1);
    chk("max_saturated", coins_issued, 255);
    chk("max_remaining", remaining, 0);
    tick();

    cmp_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
